param_seq_multiplier: RTL and testbench
=======================================

// Module: param_seq_multiplier
// PURPOSE
//  Parametrised shift-add sequential multiplier, successor to the fixed 8x8 unit.
//  Multiplies two WIDTH-bit operands, signed or unsigned per run, one partial product per cycle.
//  Adds a busy flag, load-restart semantics and optional early termination.
//  Sits as an iterative arithmetic engine beside datapath logic that can tolerate multi-cycle latency.
// PARAMETERS
//  WIDTH    8   operand width in bits, >=2; product is 2*WIDTH bits
//  CNT_W    $clog2(WIDTH+1)   derived width of the step counter; do not override
// PORTS
//  clk          in   1         rising-edge clock
//  asyn_rst     in   1         asynchronous, active-low reset
//  load         in   1         start strobe; sampled on each rising clk edge
//  signed_mode  in   1         1: a and b are two's complement; 0: unsigned; sampled with load
//  a            in   WIDTH     multiplicand; sampled with load
//  b            in   WIDTH     multiplier; sampled with load
//  product      out  2*WIDTH   result; held until the next load or reset
//  valid        out  1         product is valid; level, not a pulse
//  busy         out  1         multiplication in progress
// BEHAVIOUR
//  - Reset (asyn_rst=0, immediate, no clk needed): product=0, valid=0, busy=0, state IDLE, counter=0.
//  - States: IDLE -> BUSY on load; BUSY -> DONE on the final step; DONE -> BUSY on load.
//    load is accepted in every state, including BUSY.
//  - Load edge: capture |a| and |b| as WIDTH-bit magnitudes, neg = signed_mode & (a[W-1]^b[W-1]).
//    Clear the accumulator and counter. Set busy=1, valid=0; product keeps its old value.
//  - Each BUSY edge: if mplier[0], acc += mcand << step; mplier >>= 1; counter++.
//  - Final step is the WIDTH-th BUSY edge. It writes product = neg ? -acc : acc (2*WIDTH wrap) and sets valid=1, busy=0.
//  - Latency: valid rises exactly WIDTH edges after the load edge.
//  - Load during BUSY aborts the current run with no valid for it, then restarts with the new operands.
//  - Load in DONE drops valid on that same edge.
//  - Magnitude of -2^(W-1) is 2^(W-1) (fits unsigned W bits).
//    (-2^(W-1))^2 = 2^(2W-2) fits in the product.
//  - signed_mode=0: operands are pure unsigned and the result is never negated.
//  - busy and valid are never both 1.
//  - X/Z on a or b: no requirement on product. The valid/busy timing must be unaffected.
// CONFIGURATION
//  PSM_EARLY_DONE_EN defined:
//    - BUSY also finishes on the edge after which the shifted multiplier is 0.
//    - Latency = max(1, index of highest set bit of |b| + 1).
//    - b=0 gives valid 1 edge after load, with product=0.
//  PSM_EARLY_DONE_EN undefined:
//    - Fixed latency of WIDTH edges for all operands. No zero-detect logic is built.
// STRUCTURE
//  - Package psm_pkg: state encoding (IDLE=2'd0, BUSY=2'd1, DONE=2'd2) and a clog2 helper for CNT_W.
//  - Sub-module psm_sign_adj: combinational abs/negate of a 2*WIDTH value, used for operand magnitude and result fix-up.
//  - All else lives in param_seq_multiplier: FSM, counter, accumulator, shift registers.
// TESTING  (WIDTH=8, 10 ns clock; Tl = load edge)
//  1. Unsigned 183*197 (0xB7*0xC5), signed_mode=0 -> busy Tl..Tl+7.
//     valid=1 and product=0x8CD3 (36051) at Tl+8.
//  2. Signed 0xB7*0xC5 (-73*-59) -> product=0x10D3 (4307).
//     Signed 0xB7*0x67 (-73*103) -> product=0xE2A1 (-7519). Both at Tl+8.
//  3. Load 183*197, then load 149*103 two edges later -> valid never rises for the first run.
//     product=0x3BF3 (15347), valid=1 exactly 8 edges after the second load.
//  4. Drop asyn_rst mid-BUSY between edges -> product=0, valid=0, busy=0 before the next edge.
//     No valid after release until a new load.
//  5. Corners: signed 0x80*0x80 -> 0x4000; unsigned 0xFF*0xFF -> 0xFE01; signed 0x7F*0x80 -> 0xC080.
//  6. Early-done: with PSM_EARLY_DONE_EN, b=0x01 -> valid at Tl+1 with product=a.
//     b=0x00 -> valid at Tl+1 with product=0. Without the macro, both give valid at Tl+8.

Source files
------------

// File: rtl/psm_pkg.sv
// Shared types for the parametrised shift-add sequential multiplier:
// FSM state encoding and a clog2 helper used to size the step counter.
package psm_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } psm_state_t;

    function automatic int psm_clog2(input int value);
        int r;
        int v;
        r = 0;
        v = value - 1;
        while (v > 0) begin
            r = r + 1;
            v = v >> 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/psm_sign_adj.sv
// Combinational conditional two's-complement negate of a W-bit value.
// Ports: i_val (value), i_neg (negate when 1), o_val (result, wraps mod 2^W).
module psm_sign_adj #(
    parameter int W = 16
) (
    input  logic [W-1:0] i_val,
    input  logic         i_neg,
    output logic [W-1:0] o_val
);

    assign o_val = i_neg ? (~i_val + W'(1)) : i_val;

endmodule

// File: rtl/param_seq_multiplier.sv
// Shift-add sequential multiplier, WIDTH x WIDTH -> 2*WIDTH, signed or unsigned.
// Ports: clk, asyn_rst (async active-low), load/signed_mode/a/b in; product/valid/busy out.
// Optional macro PSM_EARLY_DONE_EN: finish as soon as the remaining multiplier is zero.
module param_seq_multiplier
    import psm_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = psm_clog2(WIDTH + 1)
) (
    input  logic               clk,
    input  logic               asyn_rst,
    input  logic               load,
    input  logic               signed_mode,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic [2*WIDTH-1:0] product,
    output logic               valid,
    output logic               busy
);

    localparam int PW = 2 * WIDTH;

    psm_state_t       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [PW-1:0]    r_acc;
    logic [WIDTH-1:0] r_mcand;
    logic [WIDTH-1:0] r_mplier;
    logic             r_neg;
    logic [PW-1:0]    r_product;
    logic             r_valid;
    logic             r_busy;

    logic [WIDTH-1:0] w_mag_a;
    logic [WIDTH-1:0] w_mag_b;
    logic [PW-1:0]    w_add;
    logic [PW-1:0]    w_acc_nxt;
    logic [PW-1:0]    w_res;
    logic             w_last;
    logic             w_fin;

    // Negating -2^(W-1) in W bits yields 2^(W-1), which is the correct
    // unsigned magnitude, so no extra bit is needed for the operands.
    psm_sign_adj #(.W(WIDTH)) u_abs_a (
        .i_val (a),
        .i_neg (signed_mode & a[WIDTH-1]),
        .o_val (w_mag_a)
    );

    psm_sign_adj #(.W(WIDTH)) u_abs_b (
        .i_val (b),
        .i_neg (signed_mode & b[WIDTH-1]),
        .o_val (w_mag_b)
    );

    assign w_add     = r_mplier[0]
                     ? ({{WIDTH{1'b0}}, r_mcand} << r_cnt)
                     : '0;
    assign w_acc_nxt = r_acc + w_add;

    psm_sign_adj #(.W(PW)) u_fix (
        .i_val (w_acc_nxt),
        .i_neg (r_neg),
        .o_val (w_res)
    );

    assign w_last = (r_cnt == CNT_W'(WIDTH - 1));

`ifdef PSM_EARLY_DONE_EN
    // Remaining multiplier bits all zero: nothing more can be added.
    assign w_fin = w_last | (r_mplier[WIDTH-1:1] == '0);
`else
    assign w_fin = w_last;
`endif

    always_ff @(posedge clk or negedge asyn_rst) begin
        if (!asyn_rst) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_acc     <= '0;
            r_mcand   <= '0;
            r_mplier  <= '0;
            r_neg     <= 1'b0;
            r_product <= '0;
            r_valid   <= 1'b0;
            r_busy    <= 1'b0;
        end else if (load) begin
            // Accepted in any state; aborts a run in progress.
            r_state  <= S_BUSY;
            r_cnt    <= '0;
            r_acc    <= '0;
            r_mcand  <= w_mag_a;
            r_mplier <= w_mag_b;
            r_neg    <= signed_mode & (a[WIDTH-1] ^ b[WIDTH-1]);
            r_valid  <= 1'b0;
            r_busy   <= 1'b1;
        end else begin
            case (r_state)
                S_BUSY: begin
                    r_acc    <= w_acc_nxt;
                    r_mplier <= r_mplier >> 1;
                    r_cnt    <= r_cnt + CNT_W'(1);
                    if (w_fin) begin
                        r_product <= w_res;
                        r_valid   <= 1'b1;
                        r_busy    <= 1'b0;
                        r_state   <= S_DONE;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign product = r_product;
    assign valid   = r_valid;
    assign busy    = r_busy;

endmodule

// File: tb/tb_param_seq_multiplier.sv
// Directed self-checking bench for param_seq_multiplier at WIDTH=8.
// Build with or without PSM_EARLY_DONE_EN; expected latency follows it.
module tb_param_seq_multiplier;

    localparam int W = 8;
`ifdef PSM_EARLY_DONE_EN
    localparam int LAT_B01 = 1;
`else
    localparam int LAT_B01 = W;
`endif

    logic           clk;
    logic           asyn_rst;
    logic           load;
    logic           signed_mode;
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic [2*W-1:0] product;
    logic           valid;
    logic           busy;

    int n_chk;
    int n_fail;

    param_seq_multiplier #(.WIDTH(W)) dut (
        .clk         (clk),
        .asyn_rst    (asyn_rst),
        .load        (load),
        .signed_mode (signed_mode),
        .a           (a),
        .b           (b),
        .product     (product),
        .valid       (valid),
        .busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h",
                     tag, got, exp);
        end
    endtask

    // Present operands and hold load across exactly one rising edge.
    task automatic start(input logic sm,
                         input logic [W-1:0] ia,
                         input logic [W-1:0] ib);
        @(negedge clk);
        load        = 1'b1;
        signed_mode = sm;
        a           = ia;
        b           = ib;
        @(posedge clk);
        #1;
        load = 1'b0;
    endtask

    // Edges after the load edge until valid; 0 on timeout.
    // gaps counts edges with busy low before valid or busy&valid.
    task automatic wait_done(output int lat, output int gaps);
        lat  = 0;
        gaps = 0;
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk);
            #1;
            if (valid && busy) gaps++;
            if (valid) begin
                lat = k;
                break;
            end
            if (!busy) gaps++;
        end
    endtask

    task automatic run(input string tag,
                       input logic sm,
                       input logic [W-1:0] ia,
                       input logic [W-1:0] ib,
                       input logic [2*W-1:0] exp_p,
                       input int exp_lat);
        int lat;
        int gaps;
        start(sm, ia, ib);
        chk({tag, "_ldbusy"}, 32'(busy), 32'd1);
        chk({tag, "_ldvalid"}, 32'(valid), 32'd0);
        wait_done(lat, gaps);
        chk({tag, "_lat"}, 32'(lat), 32'(exp_lat));
        chk({tag, "_gaps"}, 32'(gaps), 32'd0);
        chk({tag, "_prod"}, 32'(product), 32'(exp_p));
    endtask

    initial begin
        int lat;
        int gaps;
        n_chk       = 0;
        n_fail      = 0;
        asyn_rst    = 1'b0;
        load        = 1'b0;
        signed_mode = 1'b0;
        a           = '0;
        b           = '0;
        #3;
        chk("rst_prod", 32'(product), 32'd0);
        chk("rst_valid", 32'(valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        @(negedge clk);
        asyn_rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("idle_valid", 32'(valid), 32'd0);

        run("u_b7c5", 1'b0, 8'hB7, 8'hC5, 16'h8CD3, W);
        repeat (2) @(posedge clk);
        #1;
        chk("hold_valid", 32'(valid), 32'd1);
        chk("hold_prod", 32'(product), 32'h8CD3);

        run("s_b7c5", 1'b1, 8'hB7, 8'hC5, 16'h10D3, W);
        run("s_b767", 1'b1, 8'hB7, 8'h67, 16'hE2A1, W);

        // Restart mid-run: first result must never appear.
        start(1'b0, 8'hB7, 8'hC5);
        @(posedge clk);
        #1;
        chk("ab_busy1", 32'(busy), 32'd1);
        chk("ab_valid1", 32'(valid), 32'd0);
        start(1'b0, 8'h95, 8'h67);
        chk("ab_ldprod", 32'(product), 32'hE2A1);
        wait_done(lat, gaps);
        chk("ab_lat", 32'(lat), 32'(W));
        chk("ab_gaps", 32'(gaps), 32'd0);
        chk("ab_prod", 32'(product), 32'h3BF3);

        // Asynchronous reset between edges mid-run.
        start(1'b0, 8'hB7, 8'hC5);
        repeat (3) @(posedge clk);
        #2;
        asyn_rst = 1'b0;
        #1;
        chk("ar_prod", 32'(product), 32'd0);
        chk("ar_valid", 32'(valid), 32'd0);
        chk("ar_busy", 32'(busy), 32'd0);
        @(negedge clk);
        asyn_rst = 1'b1;
        wait_done(lat, gaps);
        chk("ar_novalid", 32'(lat), 32'd0);
        chk("ar_idle_busy", 32'(busy), 32'd0);

        run("s_8080", 1'b1, 8'h80, 8'h80, 16'h4000, W);
        run("u_ffff", 1'b0, 8'hFF, 8'hFF, 16'hFE01, W);
        run("s_7f80", 1'b1, 8'h7F, 8'h80, 16'hC080, W);
        run("u_b701", 1'b0, 8'hB7, 8'h01, 16'h00B7, LAT_B01);
        run("u_b700", 1'b0, 8'hB7, 8'h00, 16'h0000, LAT_B01);
        run("s_ff03", 1'b1, 8'hFF, 8'h03, 16'hFFFD, W);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
